// File: rtl/ppg_align_pkg.sv
// ppg_align_pkg: shared defaults, aligned-width helper and beat struct for the partial-product align pipe.
package ppg_align_pkg;
  localparam int LANES_DEF = 9;
  localparam int PP_W_DEF  = 5;
  localparam int EXP_W_DEF = 5;
  localparam int GUARD_DEF = 3;

  function automatic int al_w(input int pp_w, input int guard);
    return pp_w + guard;
  endfunction

  localparam int AL_W_DEF = al_w(PP_W_DEF, GUARD_DEF);

  typedef struct packed {
    logic [LANES_DEF*AL_W_DEF-1:0]  pp;
    logic [LANES_DEF-1:0]           sticky;
    logic [LANES_DEF*EXP_W_DEF-1:0] shift;
    logic [LANES_DEF-1:0]           ovf;
    logic [EXP_W_DEF-1:0]           exp_max;
    logic [EXP_W_DEF-1:0]           exp_bias;
  } beat_t;
endpackage

// File: rtl/ppg_align_stage.sv
// ppg_align_stage: one elastic register stage with valid bit, advance logic and synchronous flush.
module ppg_align_stage
  import ppg_align_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic i_valid,
  input  T     i_data,
  input  logic i_adv_next,
  output logic o_valid,
  output T     o_data,
  output logic o_adv
);
  logic r_valid;
  T     r_data;

  assign o_adv   = !r_valid || i_adv_next;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // flush clears only the valid bit; payload is left as-is
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= flush ? 1'b0 : (o_adv ? i_valid : r_valid);
      if (o_adv && !flush) r_data <= i_data;
    end
  end
endmodule

// File: rtl/ppg_align_pipe.sv
// ppg_align_pipe: aligns partial products to exp_max and carries them through a DEPTH-stage elastic pipeline.
module ppg_align_pipe
  import ppg_align_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int PP_W  = PP_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES*PP_W-1:0]                   in_pp,
  input  logic [LANES*EXP_W-1:0]                  in_exp,
  input  logic [EXP_W-1:0]                        in_exp_max,
  input  logic [EXP_W-1:0]                        in_exp_bias,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LANES*al_w(PP_W, GUARD)-1:0]      out_pp,
  output logic [LANES-1:0]                        out_sticky,
  output logic [LANES*EXP_W-1:0]                  out_shift,
  output logic [LANES-1:0]                        out_ovf,
  output logic [EXP_W-1:0]                        out_exp_max,
  output logic [EXP_W-1:0]                        out_exp_bias
);
  localparam int AL_W = al_w(PP_W, GUARD);

  typedef struct packed {
    logic [LANES*AL_W-1:0]  pp;
    logic [LANES-1:0]       sticky;
    logic [LANES*EXP_W-1:0] shift;
    logic [LANES-1:0]       ovf;
    logic [EXP_W-1:0]       exp_max;
    logic [EXP_W-1:0]       exp_bias;
  } beat_w_t;

  beat_w_t                w_beat  [DEPTH+1];
  logic                   w_valid [DEPTH+1];
  logic                   w_adv   [DEPTH+1];
  logic [LANES*AL_W-1:0]  w_al;
  logic [LANES-1:0]       w_st;
  logic [LANES*EXP_W-1:0] w_sh;
  logic [LANES-1:0]       w_ov;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PP_W-1:0]          w_pp;
    logic [EXP_W-1:0]         w_exp;
    logic [EXP_W-1:0]         w_d;
    logic signed [AL_W-1:0]   w_ext;
    logic [AL_W-1:0]          w_shr;
    logic                     w_big;
    assign w_pp  = in_pp[l*PP_W +: PP_W];
    assign w_exp = in_exp[l*EXP_W +: EXP_W];
    assign w_ov[l] = w_exp > in_exp_max;
    assign w_d   = w_ov[l] ? '0 : in_exp_max - w_exp;
    assign w_ext = {w_pp, {GUARD{1'b0}}};
    // kept as its own assignment so the shift stays signed (arithmetic)
    assign w_shr = w_ext >>> w_d;
    assign w_big = int'(w_d) >= AL_W;
    assign w_al[l*AL_W +: AL_W] = w_big ? {AL_W{w_pp[PP_W-1]}} : w_shr;
    // mask of the bits shifted below bit 0; all-ones once d >= AL_W
    assign w_st[l] = |(w_ext & ~({AL_W{1'b1}} << w_d));
    assign w_sh[l*EXP_W +: EXP_W] = w_d;
  end

  assign w_beat[0]  = '{pp: w_al, sticky: w_st, shift: w_sh, ovf: w_ov,
                        exp_max: in_exp_max, exp_bias: in_exp_bias};
  assign w_adv[DEPTH] = out_ready;
  assign in_ready   = w_adv[0] && !flush;
  assign w_valid[0] = in_valid && in_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    ppg_align_stage #(.T(beat_w_t)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .i_valid   (w_valid[k]),
      .i_data    (w_beat[k]),
      .i_adv_next(w_adv[k+1]),
      .o_valid   (w_valid[k+1]),
      .o_data    (w_beat[k+1]),
      .o_adv     (w_adv[k])
    );
  end

  assign out_valid    = w_valid[DEPTH];
  assign out_pp       = w_beat[DEPTH].pp;
  assign out_sticky   = w_beat[DEPTH].sticky;
  assign out_shift    = w_beat[DEPTH].shift;
  assign out_ovf      = w_beat[DEPTH].ovf;
  assign out_exp_max  = w_beat[DEPTH].exp_max;
  assign out_exp_bias = w_beat[DEPTH].exp_bias;
endmodule

// File: tb/tb_ppg_align_pipe.sv
// tb_ppg_align_pipe: directed checks on the default pipe plus a random sweep of DEPTH=1/4, LANES=4 variants.
module tb_ppg_align_pipe;
  localparam int BEATS = 10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [44:0] in_pp = '0;
  logic [44:0] in_exp = '0;
  logic [4:0]  in_exp_max = '0;
  logic [4:0]  in_exp_bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [71:0] out_pp;
  logic [8:0]  out_sticky;
  logic [44:0] out_shift;
  logic [8:0]  out_ovf;
  logic [4:0]  out_exp_max;
  logic [4:0]  out_exp_bias;

  logic        s_in_valid [2];
  logic        s_in_ready [2];
  logic [19:0] s_in_pp [2];
  logic [19:0] s_in_exp [2];
  logic [4:0]  s_emax [2];
  logic [4:0]  s_bias [2];
  logic        s_out_valid [2];
  logic        s_out_ready [2];
  logic [31:0] s_out_pp [2];
  logic [3:0]  s_sticky [2];
  logic [19:0] s_shift [2];
  logic [3:0]  s_ovf [2];
  logic [4:0]  s_omax [2];
  logic [4:0]  s_obias [2];

  int n_pass = 0;
  int n_tot = 0;

  always #5 clk = ~clk;

  ppg_align_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pp(in_pp), .in_exp(in_exp), .in_exp_max(in_exp_max), .in_exp_bias(in_exp_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_pp(out_pp), .out_sticky(out_sticky),
    .out_shift(out_shift), .out_ovf(out_ovf), .out_exp_max(out_exp_max), .out_exp_bias(out_exp_bias)
  );

  ppg_align_pipe #(.LANES(4), .DEPTH(1)) dut_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]),
    .in_pp(s_in_pp[0]), .in_exp(s_in_exp[0]), .in_exp_max(s_emax[0]), .in_exp_bias(s_bias[0]),
    .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]), .out_pp(s_out_pp[0]), .out_sticky(s_sticky[0]),
    .out_shift(s_shift[0]), .out_ovf(s_ovf[0]), .out_exp_max(s_omax[0]), .out_exp_bias(s_obias[0])
  );

  ppg_align_pipe #(.LANES(4), .DEPTH(4)) dut_d4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]),
    .in_pp(s_in_pp[1]), .in_exp(s_in_exp[1]), .in_exp_max(s_emax[1]), .in_exp_bias(s_bias[1]),
    .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]), .out_pp(s_out_pp[1]), .out_sticky(s_sticky[1]),
    .out_shift(s_shift[1]), .out_ovf(s_ovf[1]), .out_exp_max(s_omax[1]), .out_exp_bias(s_obias[1])
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [4:0] p, input logic [4:0] e);
    in_pp[l*5 +: 5]  = p;
    in_exp[l*5 +: 5] = e;
  endtask

  function automatic logic [69:0] model(input logic [19:0] pp, input logic [19:0] ex,
                                        input logic [4:0] emax, input logic [4:0] bias);
    logic [31:0] ap;
    logic [3:0] st;
    logic [3:0] ov;
    logic [19:0] sh;
    logic [4:0] p;
    logic [4:0] e;
    logic signed [7:0] ext;
    int d;
    for (int l = 0; l < 4; l++) begin
      p = pp[l*5 +: 5];
      e = ex[l*5 +: 5];
      ov[l] = e > emax;
      d = ov[l] ? 0 : int'(emax) - int'(e);
      ext = {p, 3'b000};
      sh[l*5 +: 5] = 5'(d);
      if (d >= 8) begin
        ap[l*8 +: 8] = {8{p[4]}};
        st[l] = |p;
      end else begin
        ap[l*8 +: 8] = ext >>> d;
        st[l] = 1'b0;
        for (int b = 0; b < d; b++) st[l] = st[l] | ext[b];
      end
    end
    return {ap, st, sh, ov, emax, bias};
  endfunction

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      s_in_valid[k] = 1'b0; s_in_pp[k] = '0; s_in_exp[k] = '0;
      s_emax[k] = '0; s_bias[k] = '0; s_out_ready[k] = 1'b1;
    end
    #1 rst = 1'b0;
    #1;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else n_pass++;
    n_tot++; if (out_pp !== 72'd0 || out_shift !== 45'd0) $display("FAIL rst_data got pp=%h shift=%h exp 0", out_pp, out_shift); else n_pass++;
    n_tot++; if (out_sticky !== 9'd0 || out_ovf !== 9'd0 || out_exp_max !== 5'd0 || out_exp_bias !== 5'd0)
      $display("FAIL rst_flags got st=%b ov=%b max=%h bias=%h exp 0", out_sticky, out_ovf, out_exp_max, out_exp_bias); else n_pass++;
    @(negedge clk) rst = 1'b1;
    step;
    n_tot++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rst_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_align;
    logic [71:0] ep;
    logic [44:0] es;
    in_pp = '0;
    in_exp = {9{5'd5}};
    set_lane(0, 5'b01100, 5'd3);
    set_lane(1, 5'b10011, 5'd4);
    set_lane(2, 5'b00111, 5'd1);
    in_exp_max = 5'd5; in_exp_bias = 5'd7; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    n_tot++; if (in_ready !== 1'b1) $display("FAIL align_accept got %b exp 1", in_ready); else n_pass++;
    step;
    in_valid = 1'b0;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL align_lat1 got %b exp 0", out_valid); else n_pass++;
    step;
    ep = '0; ep[7:0] = 8'b00011000; ep[15:8] = 8'b11001100; ep[23:16] = 8'b00000011;
    es = '0; es[4:0] = 5'd2; es[9:5] = 5'd1; es[14:10] = 5'd4;
    n_tot++; if (out_valid !== 1'b1) $display("FAIL align_lat2 got %b exp 1", out_valid); else n_pass++;
    n_tot++; if (out_pp !== ep) $display("FAIL align_pp got %h exp %h", out_pp, ep); else n_pass++;
    n_tot++; if (out_sticky !== 9'b000000100) $display("FAIL align_sticky got %b exp 000000100", out_sticky); else n_pass++;
    n_tot++; if (out_shift !== es) $display("FAIL align_shift got %h exp %h", out_shift, es); else n_pass++;
    n_tot++; if (out_ovf !== 9'd0 || out_exp_max !== 5'd5 || out_exp_bias !== 5'd7)
      $display("FAIL align_meta got ov=%b max=%0d bias=%0d exp 0/5/7", out_ovf, out_exp_max, out_exp_bias); else n_pass++;
    step;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL align_single got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_saturation;
    logic [71:0] ep;
    logic [44:0] es;
    in_pp = '0;
    in_exp = {9{5'd12}};
    set_lane(0, 5'b00001, 5'd2);
    set_lane(1, 5'b10000, 5'd2);
    set_lane(2, 5'b01011, 5'd13);
    set_lane(3, 5'b10101, 5'd12);
    set_lane(4, 5'b10001, 5'd5);
    set_lane(5, 5'b01000, 5'd4);
    in_exp_max = 5'd12; in_exp_bias = 5'd3; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    ep = '0; ep[15:8] = 8'hff; ep[23:16] = 8'b01011000; ep[31:24] = 8'b10101000; ep[39:32] = 8'hff;
    es = '0; es[4:0] = 5'd10; es[9:5] = 5'd10; es[24:20] = 5'd7; es[29:25] = 5'd8;
    n_tot++; if (out_valid !== 1'b1) $display("FAIL sat_valid got %b exp 1", out_valid); else n_pass++;
    n_tot++; if (out_pp !== ep) $display("FAIL sat_pp got %h exp %h", out_pp, ep); else n_pass++;
    n_tot++; if (out_sticky !== 9'b000110011) $display("FAIL sat_sticky got %b exp 000110011", out_sticky); else n_pass++;
    n_tot++; if (out_shift !== es) $display("FAIL sat_shift got %h exp %h", out_shift, es); else n_pass++;
    n_tot++; if (out_ovf !== 9'b000000100) $display("FAIL sat_ovf got %b exp 000000100", out_ovf); else n_pass++;
    step;
  endtask

  task automatic test_back_to_back;
    int nxt = 1;
    int dlv = 1;
    logic [4:0] prev_bias = '0;
    logic prev_stall = 1'b0;
    in_pp = '0; in_exp = '0; in_exp_max = 5'd3;
    for (int c = 0; c < 40 && dlv <= 8; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid = nxt <= 8;
      in_exp_bias = 5'(nxt);
      @(negedge clk);
      if (prev_stall) begin
        n_tot++;
        if (out_valid !== 1'b1 || out_exp_bias !== prev_bias)
          $display("FAIL bp_stable cycle %0d got vld=%b bias=%0d exp 1/%0d", c, out_valid, out_exp_bias, prev_bias);
        else n_pass++;
      end
      if (c >= 3 && c <= 5) begin
        n_tot++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b exp 0", c, in_ready); else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_tot++; if (out_exp_bias !== 5'(dlv)) $display("FAIL bp_order got %0d exp %0d", out_exp_bias, dlv); else n_pass++;
        dlv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_bias = out_exp_bias;
      if (in_valid && in_ready) nxt++;
      step;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tot++; if (dlv !== 9) $display("FAIL bp_count got %0d exp 9", dlv - 1); else n_pass++;
    step; step;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush;
    out_ready = 1'b1; in_valid = 1'b1; in_exp_bias = 5'd10;
    step;
    in_exp_bias = 5'd11;
    step;
    n_tot++; if (out_valid !== 1'b1 || out_exp_bias !== 5'd10) $display("FAIL fl_inflight got vld=%b bias=%0d exp 1/10", out_valid, out_exp_bias); else n_pass++;
    in_exp_bias = 5'd12; flush = 1'b1;
    @(negedge clk);
    n_tot++; if (in_ready !== 1'b0) $display("FAIL fl_in_ready got %b exp 0", in_ready); else n_pass++;
    step;
    flush = 1'b0;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL fl_cleared got %b exp 0", out_valid); else n_pass++;
    @(negedge clk);
    n_tot++; if (in_ready !== 1'b1) $display("FAIL fl_ready_back got %b exp 1", in_ready); else n_pass++;
    step;
    in_valid = 1'b0;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL fl_lat1 got %b exp 0", out_valid); else n_pass++;
    step;
    n_tot++; if (out_valid !== 1'b1 || out_exp_bias !== 5'd12) $display("FAIL fl_next got vld=%b bias=%0d exp 1/12", out_valid, out_exp_bias); else n_pass++;
    step;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL fl_no_dup got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid;
    in_pp = '0; in_exp = '0; in_exp_max = 5'd9; in_exp_bias = 5'd21;
    set_lane(0, 5'b01100, 5'd9);
    in_valid = 1'b1; out_ready = 1'b1;
    step; step; step;
    n_tot++; if (out_valid !== 1'b1 || out_pp[7:0] !== 8'b01100000) $display("FAIL rm_pre got vld=%b pp=%h exp 1/60", out_valid, out_pp[7:0]); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", out_valid); else n_pass++;
    n_tot++; if (out_pp !== 72'd0 || out_shift !== 45'd0 || out_exp_max !== 5'd0 || out_exp_bias !== 5'd0)
      $display("FAIL rm_data got pp=%h sh=%h max=%0d bias=%0d exp 0", out_pp, out_shift, out_exp_max, out_exp_bias); else n_pass++;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    n_tot++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready got %b exp 1", in_ready); else n_pass++;
    step;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL rm_idle got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_sweep;
    logic [69:0] q0 [$];
    logic [69:0] q1 [$];
    logic [69:0] got;
    logic [69:0] expv;
    int sent [2];
    int dlvd [2];
    sent = '{0, 0};
    dlvd = '{0, 0};
    for (int c = 0; c < 80000 && (dlvd[0] < BEATS || dlvd[1] < BEATS); c++) begin
      for (int k = 0; k < 2; k++) begin
        s_in_valid[k] = sent[k] < BEATS && $urandom_range(3) != 0;
        s_in_pp[k] = 20'($urandom);
        s_in_exp[k] = 20'($urandom);
        s_emax[k] = 5'($urandom);
        s_bias[k] = 5'($urandom);
        s_out_ready[k] = $urandom_range(3) != 0;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (s_out_valid[k] && s_out_ready[k]) begin
          got = {s_out_pp[k], s_sticky[k], s_shift[k], s_ovf[k], s_omax[k], s_obias[k]};
          if (k == 0 && q0.size() > 0) expv = q0.pop_front();
          else if (k == 1 && q1.size() > 0) expv = q1.pop_front();
          else expv = 'x;
          n_tot++;
          if (got !== expv) $display("FAIL sweep_depth%0d beat %0d got %h exp %h", k == 0 ? 1 : 4, dlvd[k], got, expv);
          else n_pass++;
          dlvd[k]++;
        end
        if (s_in_valid[k] && s_in_ready[k]) begin
          expv = model(s_in_pp[k], s_in_exp[k], s_emax[k], s_bias[k]);
          if (k == 0) q0.push_back(expv); else q1.push_back(expv);
          sent[k]++;
        end
      end
      step;
    end
    for (int k = 0; k < 2; k++) s_in_valid[k] = 1'b0;
    n_tot++;
    if (dlvd[0] != BEATS || dlvd[1] != BEATS || q0.size() != 0 || q1.size() != 0)
      $display("FAIL sweep_count got d1=%0d d4=%0d exp %0d each", dlvd[0], dlvd[1], BEATS);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_align();
    test_saturation();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ppg_align_pipe.md
Name: ppg_align_pipe

Overview:
Parametrised successor to the SD4 MAC partial-product/exponent pipeline register, sitting between the partial-product generator and the adder tree. Carries LANES partial products, their exponents, exp_max and exp_bias through a DEPTH-stage elastic pipeline with a valid/ready handshake and a synchronous flush. Stage 0 also aligns each partial product to exp_max, so the adder tree receives pre-shifted operands, per-lane sticky bits and overflow flags.

Parameters:
LANES, 9, number of partial-product lanes
PP_W, 5, partial-product width (two's complement)
EXP_W, 5, exponent width (unsigned)
GUARD, 3, guard bits appended below the LSB before shifting; AL_W = PP_W + GUARD
DEPTH, 2, number of register stages (>= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline clear
in_valid  in  1  input beat valid
in_ready  out  1  pipeline can accept a beat
in_pp  in  LANES*PP_W  packed partial products, lane 0 in the LSBs
in_exp  in  LANES*EXP_W  packed per-lane exponents
in_exp_max  in  EXP_W  maximum exponent of the beat
in_exp_bias  in  EXP_W  exponent bias, passed through unchanged
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_pp  out  LANES*AL_W  aligned partial products
out_sticky  out  LANES  OR of the bits shifted out, per lane
out_shift  out  LANES*EXP_W  applied shift distance, per lane
out_ovf  out  LANES  exp_i > exp_max, per lane
out_exp_max  out  EXP_W  delayed exp_max
out_exp_bias  out  EXP_W  delayed exp_bias

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low.
- Reset clears every register to 0:
  - all stage valid bits;
  - out_valid, out_pp, out_sticky, out_shift, out_ovf, out_exp_max, out_exp_bias.
  - in_ready is 1 while stage 0 is empty, so it reads 1 out of reset.
- Stage k advance condition:
  - adv_k = !valid_k || adv_(k+1), where adv_DEPTH = out_ready.
  - Ready propagates combinationally through the stages.
  - in_ready = adv_0 && !flush.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - It is delivered when out_valid && out_ready.
  - out_valid = valid_(DEPTH-1).
  - While out_valid is 1 and out_ready is 0, all out_* signals hold stable.
  - No beat is dropped or duplicated.
  - A stage whose adv is 0 holds both its data and its valid bit.
  - A stage may capture a bubble (valid 0); its data is then don't-care.
- Latency and throughput:
  - DEPTH cycles from acceptance to out_valid, with no backpressure.
  - Sustained 1 beat per cycle while out_ready is held at 1.
- Flush:
  - Synchronous: all valid bits clear on the next edge; data registers are untouched.
  - Flush overrides accept, so in_ready is 0 in that cycle.
  - A beat presented with out_ready=1 in the flush cycle is still counted as delivered by the downstream block.
- Alignment (combinational before stage 0, registered in stage 0), per lane i:
  - Overflow: if exp_i > exp_max then ovf_i=1, d=0. Otherwise ovf_i=0, d = exp_max - exp_i.
  - Shift: ext = {pp_i, GUARD'b0}; aligned = ext >>> d (arithmetic, sign fill).
  - Large shift: if d >= AL_W, aligned = AL_W copies of the sign bit.
  - Sticky: sticky_i = OR of the bits of ext shifted below bit 0. When d >= AL_W, sticky_i = |pp_i.
  - out_shift_i = d, unsaturated.
- exp_max and exp_bias travel with the beat through every stage.
- Reset mid-stream: all in-flight beats are lost. out_valid is 0 from reset assertion until the first new beat has passed DEPTH stages.

Decomposition:
- Shared package ppg_align_pkg holds:
  - defaults for LANES, PP_W, EXP_W, GUARD;
  - the AL_W derivation function;
  - a packed beat struct {pp, sticky, shift, ovf, exp_max, exp_bias} used by every stage.
- Sub-module ppg_align_stage: one elastic register stage with valid bit, advance logic and flush.
  - Instantiated DEPTH times by a generate loop.
  - The alignment logic stays in the top level, ahead of stage 0.

Test Plan:
- Align, DEPTH=2, exp_max=5, out_ready=1:
  - lane0 pp=01100, exp=3 -> out_pp=00011000, sticky=0, shift=2;
  - lane1 pp=10011, exp=4 -> out_pp=11001100, sticky=0;
  - lane2 pp=00111, exp=1 -> 00000011, sticky=1;
  - out_valid exactly 2 cycles after accept.
- Saturation and overflow:
  - exp_max=12, lane pp=00001, exp=2 (d=10) -> 00000000, sticky=1, shift=10;
  - lane pp=10000, exp=2 -> 11111111, sticky=1;
  - lane exp=13 -> ovf=1, shift=0, out_pp={pp,000}.
- Backpressure:
  - Stream beats tagged exp_bias=1..8 with in_valid held at 1.
  - Hold out_ready=0 for cycles 3-5 -> in_ready drops once both stages are full.
  - out_* stay stable throughout.
  - Delivery order is exactly 1..8 with no gaps or duplicates.
- Flush:
  - With 2 beats in flight, pulse flush for 1 cycle -> in_ready=0 that cycle.
  - out_valid=0 the next cycle.
  - The next accepted beat emerges after DEPTH cycles.
- Reset mid-stream: assert rst asynchronously between clock edges -> all outputs 0 immediately and in_ready=1 after release.
- Configuration sweep: DEPTH=1 and DEPTH=4, LANES=4, random stimulus against a reference model, with random out_ready -> zero mismatches over 10k beats.
